// File: rtl/alu_issue_wb_pkg.sv
// Shared constants, payload types and op-decode helpers for the ALU issue/write-back stage.
package alu_issue_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOT = 3'b100;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Op held in the EX register while it waits for the ALU and the WB slot.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } ex_op_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_NOT);
  endfunction

  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_wb_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port, r0 reads 0.
module alu_regfile
  import alu_issue_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Writes to r0 are dropped here so callers need not filter them.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand-issue and write-back stage around an external combinational ALU:
// EX register feeds the ALU, WB register captures the result and retires it to the regfile.
module alu_issue_wb
  import alu_issue_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_imm_en,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_opA,
  output logic [DATA_W-1:0] alu_opB,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags,
  output logic              err
);

  ex_op_t            ex_q, ex_d;
  logic              ex_valid_q, ex_valid_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              err_q, err_d;

  logic              ex_adv_c;
  logic              accept_c;
  logic              rf_we_c;
  logic [DATA_W-1:0] rs1_data_c;
  logic [DATA_W-1:0] rs2_data_c;

  alu_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (ex_q.rs1),
    .rdata_a (rs1_data_c),
    .raddr_b (ex_q.rs2),
    .rdata_b (rs2_data_c),
    .we      (rf_we_c),
    .waddr   (ex_q.rd),
    .wdata   (alu_res)
  );

  assign ex_adv_c = ex_valid_q && (!wb_valid_q || wb_ready);
  assign accept_c = in_valid && in_ready;
  assign in_ready = !ex_valid_q || ex_adv_c;

  // ALU inputs are forced to zero while EX is empty.
  assign alu_opA = ex_valid_q ? rs1_data_c : '0;
  assign alu_opB = !ex_valid_q ? '0 : (ex_q.imm_en ? ex_q.imm : rs2_data_c);
  assign alu_sel = ex_valid_q ? ex_q.op : '0;

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    flags_d    = flags_q;
    err_d      = err_q;
    rf_we_c    = 1'b0;

    if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end

    // Retire the EX op; an illegal op only raises err and leaves no record.
    if (ex_adv_c) begin
      ex_valid_d = 1'b0;
      if (is_legal_op(ex_q.op)) begin
        wb_valid_d      = 1'b1;
        wb_rd_d         = ex_q.rd;
        wb_data_d       = alu_res;
        rf_we_c         = 1'b1;
        flags_d[FLAG_Z] = alu_z;
        if (is_arith_op(ex_q.op)) begin
          flags_d[FLAG_C] = alu_c;
          flags_d[FLAG_V] = alu_v;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (accept_c) begin
      ex_valid_d = 1'b1;
      ex_d       = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                     imm_en: in_imm_en, imm: in_imm};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign flags    = flags_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural ALU on the ALU port, reference regfile/flag model and a
// write-back scoreboard fed at issue time and drained by a negedge monitor.
module tb_alu_issue_wb;
  import alu_issue_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        in_imm_en;
  logic [31:0] in_imm;
  logic [31:0] alu_opA, alu_opB, alu_res;
  logic [2:0]  alu_sel;
  logic        alu_z, alu_c, alu_v;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  flags;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  typedef struct packed { logic z; logic c; logic v; logic [31:0] res; } alu_out_t;
  typedef struct packed { logic [2:0] rd; logic [31:0] data; } rec_t;

  logic [31:0] ref_rf [8];
  logic [2:0]  exp_flags;
  logic        exp_err;
  rec_t        exp_q[$];
  rec_t        obs_q[$];
  int unsigned obs_cyc[$];
  rec_t        mon_exp;
  rec_t        hold_rec;
  logic        hold_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_wb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .flags(flags), .err(err)
  );

  function automatic alu_out_t alu_f(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    alu_out_t r;
    logic [32:0] s;
    r = '0;
    case (sel)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[31:0]; r.c = s[32]; r.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.res = s[31:0]; r.c = s[32]; r.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'b010:  r.res = a & b;
      3'b011:  r.res = a | b;
      3'b100:  r.res = ~a;
      default: r.res = '0;
    endcase
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  // External ALU stand-in.
  always_comb begin
    {alu_z, alu_c, alu_v, alu_res} = alu_f(alu_sel, alu_opA, alu_opB);
  end

  // Write-back monitor: pops the scoreboard on each handshake and checks held records stay stable.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        n_tests++;
        if (wb_rd !== hold_rec.rd || wb_data !== hold_rec.data) begin
          n_fail++;
          $display("FAIL wb_stable: got (%0d,%h) want (%0d,%h)", wb_rd, wb_data, hold_rec.rd, hold_rec.data);
        end
      end
      if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
        obs_q.push_back({wb_rd, wb_data});
        obs_cyc.push_back(cyc);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got (%0d,%h) want no record", wb_rd, wb_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (wb_rd !== mon_exp.rd || wb_data !== mon_exp.data) begin
            n_fail++;
            $display("FAIL wb_record: got (%0d,%h) want (%0d,%h)", wb_rd, wb_data, mon_exp.rd, mon_exp.data);
          end
        end
      end
      hold_prev = (wb_valid === 1'b1) && (wb_ready === 1'b0);
      hold_rec  = {wb_rd, wb_data};
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    exp_flags = '0;
    exp_err   = 1'b0;
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // Sequential reference: ops retire in order and RAW is hazard-free, so update at issue time.
  task automatic model_push(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [31:0] imm);
    logic [31:0] a, b;
    alu_out_t r;
    a = (rs1 == 3'd0) ? 32'd0 : ref_rf[rs1];
    b = imm_en ? imm : ((rs2 == 3'd0) ? 32'd0 : ref_rf[rs2]);
    r = alu_f(op, a, b);
    if (op > 3'b100) begin
      exp_err = 1'b1;
    end else begin
      exp_q.push_back({rd, r.res});
      if (rd != 3'd0) ref_rf[rd] = r.res;
      exp_flags[2] = r.z;
      if (op <= 3'b001) begin
        exp_flags[1] = r.c;
        exp_flags[0] = r.v;
      end
    end
  endtask

  task automatic send_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic imm_en, input logic [31:0] imm,
                         output int unsigned acc_cyc);
    logic ok;
    int guard;
    model_push(op, rd, rs1, rs2, imm_en, imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm_en = imm_en; in_imm = imm;
    ok = 1'b0; guard = 0; acc_cyc = 0;
    while (!ok && guard < 64) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      acc_cyc = cyc;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want accept", guard);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    repeat (3) begin @(posedge clk); #1; end
    while ((exp_q.size() != 0 || wb_valid === 1'b1) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d records pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({in_ready, wb_valid, flags, err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b wbv=%b flags=%b err=%b want 1 0 000 0", in_ready, wb_valid, flags, err);
    end
    n_tests++;
    if (alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_sel !== 3'd0 || wb_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_alu_idle: got opA=%h opB=%h sel=%0d wbd=%h want zeros", alu_opA, alu_opB, alu_sel, wb_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int unsigned c0, c1;
    rec_t e0, e1;
    obs_q.delete(); obs_cyc.delete();
    wb_ready = 1'b1;
    send_op(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, c0);
    send_op(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'h0000_0001, c1);
    wait_drain();
    e0 = {3'd1, 32'hFFFF_FFFF};
    e1 = {3'd2, 32'h0000_0000};
    n_tests++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d records want 2", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== e0 || obs_q[1] !== e1) begin
        n_fail++;
        $display("FAIL b2b_values: got (%0d,%h)(%0d,%h) want (1,ffffffff)(2,00000000)",
                 obs_q[0].rd, obs_q[0].data, obs_q[1].rd, obs_q[1].data);
      end
      n_tests++;
      if (c1 != c0 + 1 || obs_cyc[0] != c0 + 2 || obs_cyc[1] != c0 + 3) begin
        n_fail++;
        $display("FAIL b2b_latency: got acc=%0d,%0d wb=%0d,%0d want acc=%0d,%0d wb=%0d,%0d",
                 c0, c1, obs_cyc[0], obs_cyc[1], c0, c0 + 1, c0 + 2, c0 + 3);
      end
    end
    n_tests++;
    if (flags !== 3'b110 || flags !== exp_flags) begin
      n_fail++;
      $display("FAIL b2b_flags: got %b want 110 (model %b)", flags, exp_flags);
    end
  endtask

  task automatic test_flags();
    int unsigned c;
    rec_t e;
    obs_q.delete(); obs_cyc.delete();
    wb_ready = 1'b1;
    send_op(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 32'h8000_0000, c);
    send_op(OP_SUB, 3'd4, 3'd3, 3'd0, 1'b1, 32'h0000_0001, c);
    wait_drain();
    e = {3'd4, 32'h7FFF_FFFF};
    n_tests++;
    if (obs_q.size() != 2 || obs_q[obs_q.size()-1] !== e) begin
      n_fail++;
      $display("FAIL sub_record: got %0d records want last (4,7fffffff)", obs_q.size());
    end
    n_tests++;
    if (flags !== 3'b011 || flags !== exp_flags) begin
      n_fail++;
      $display("FAIL sub_flags: got %b want 011 (model %b)", flags, exp_flags);
    end
    send_op(OP_AND, 3'd5, 3'd4, 3'd0, 1'b0, 32'h0, c);
    wait_drain();
    e = {3'd5, 32'h0};
    n_tests++;
    if (obs_q.size() != 3 || obs_q[obs_q.size()-1] !== e) begin
      n_fail++;
      $display("FAIL and_record: got %0d records want last (5,00000000)", obs_q.size());
    end
    n_tests++;
    if (flags !== 3'b111 || flags !== exp_flags) begin
      n_fail++;
      $display("FAIL and_flags: got %b want 111 (model %b)", flags, exp_flags);
    end
  endtask

  task automatic test_backpressure();
    int unsigned c;
    rec_t e [3];
    obs_q.delete(); obs_cyc.delete();
    wb_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 wb_ready = 1'b1;
      end
    join_none
    send_op(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0000_0011, c);
    send_op(OP_SUB, 3'd2, 3'd1, 3'd0, 1'b1, 32'h0000_0001, c);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    n_tests++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 32'h11) begin
      n_fail++;
      $display("FAIL bp_wb_hold: got v=%b (%0d,%h) want v=1 (1,00000011)", wb_valid, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    send_op(OP_OR, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0, c);
    wait_drain();
    e[0] = {3'd1, 32'h11}; e[1] = {3'd2, 32'h10}; e[2] = {3'd3, 32'h11};
    n_tests++;
    if (obs_q.size() != 3 || obs_q[0] !== e[0] || obs_q[1] !== e[1] || obs_q[2] !== e[2]) begin
      n_fail++;
      $display("FAIL bp_order: got %0d records want (1,11)(2,10)(3,11)", obs_q.size());
    end
    // Regfile read-back through r0 destinations, checked by the scoreboard.
    for (int r = 1; r <= 3; r++) send_op(OP_OR, 3'd0, 3'(r), 3'd0, 1'b0, 32'h0, c);
    wait_drain();
  endtask

  task automatic test_illegal();
    int unsigned c;
    rec_t e;
    obs_q.delete(); obs_cyc.delete();
    wb_ready = 1'b1;
    send_op(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'h7, c);
    send_op(3'b110, 3'd5, 3'd5, 3'd0, 1'b1, 32'h99, c);
    send_op(OP_ADD, 3'd6, 3'd5, 3'd0, 1'b1, 32'h1, c);
    wait_drain();
    e = {3'd6, 32'h8};
    n_tests++;
    if (obs_q.size() != 2 || obs_q[obs_q.size()-1] !== e) begin
      n_fail++;
      $display("FAIL illegal_records: got %0d records want 2 ending (6,00000008)", obs_q.size());
    end
    n_tests++;
    if (err !== 1'b1 || err !== exp_err) begin
      n_fail++;
      $display("FAIL illegal_err: got %b want 1", err);
    end
    n_tests++;
    if (flags !== 3'b000 || flags !== exp_flags) begin
      n_fail++;
      $display("FAIL illegal_flags: got %b want 000 (model %b)", flags, exp_flags);
    end
    send_op(OP_OR, 3'd0, 3'd5, 3'd0, 1'b0, 32'h0, c);
    wait_drain();
    e = {3'd0, 32'h7};
    n_tests++;
    if (obs_q.size() != 3 || obs_q[2] !== e) begin
      n_fail++;
      $display("FAIL illegal_rf: got %0d records want last (0,00000007)", obs_q.size());
    end
  endtask

  task automatic test_r0();
    int unsigned c;
    rec_t e0, e1;
    obs_q.delete(); obs_cyc.delete();
    wb_ready = 1'b1;
    send_op(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 32'h5, c);
    send_op(OP_OR,  3'd6, 3'd0, 3'd0, 1'b0, 32'h0, c);
    wait_drain();
    e0 = {3'd0, 32'h5};
    e1 = {3'd6, 32'h0};
    n_tests++;
    if (obs_q.size() != 2 || obs_q[0] !== e0 || obs_q[1] !== e1) begin
      n_fail++;
      $display("FAIL r0_records: got %0d records want (0,00000005)(6,00000000)", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_stall();
    int unsigned c;
    rec_t e;
    wb_ready = 1'b0;
    send_op(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 32'h1234, c);
    send_op(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'h55, c);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_tests++;
    if ({wb_valid, flags, err, in_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL rst_stall_state: got wbv=%b flags=%b err=%b rdy=%b want 0 000 0 1", wb_valid, flags, err, in_ready);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    send_op(OP_OR, 3'd0, 3'd7, 3'd0, 1'b0, 32'h0, c);
    send_op(OP_OR, 3'd0, 3'd4, 3'd0, 1'b0, 32'h0, c);
    wait_drain();
    e = {3'd0, 32'h0};
    n_tests++;
    if (obs_q.size() != 2 || obs_q[0] !== e || obs_q[1] !== e) begin
      n_fail++;
      $display("FAIL rst_stall_rf: got %0d records want (0,00000000) twice", obs_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm_en = 1'b0; in_imm = '0; wb_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_flags();
    test_backpressure();
    test_illegal();
    test_r0();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
